// File: rtl/ps2_pkg.sv
// PS/2 shared definitions for the host receiver and device transmitter.
// Frame geometry, FSM states and line idle level.
package ps2_pkg;
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = $clog2(FRAME_BITS);
  localparam logic PS2_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } ps2_state_e;
endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer plus run-length glitch filter for one PS/2 line.
// Output follows the input only after FILTER_LEN equal samples.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic line_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt_q;
  logic [CW-1:0]          cnt_q;
  logic                   samp;

  assign samp = sync_q[SYNC_STAGES-1];
  assign line_o = filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
      filt_q <= PS2_IDLE_LEVEL;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      if (samp == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        filt_q <= samp;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: rtl/ps2_frame_receiver.sv
// Host-side PS/2 frame receiver: conditions the lines and decodes
// 11-bit device-to-host frames with parity, framing and timeout status.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ps2clk,
  input  logic                 ps2data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_timeout,
  output logic                 busy
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] PAR_IDX = BIT_CNT_W'(DATA_BITS);

  logic clk_f;
  logic dat_f;
  logic clk_prev_q;
  logic fall;

  ps2_state_e             state_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   parity_q;
  logic [TO_W-1:0]        to_cnt_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   perr_q;
  logic                   ferr_q;
  logic                   to_q;

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .line_i(ps2clk),
    .line_o(clk_f)
  );

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_dat_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .line_i(ps2data),
    .line_o(dat_f)
  );

  assign fall = clk_prev_q & ~clk_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_q <= PS2_IDLE_LEVEL;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      to_cnt_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      clk_prev_q <= clk_f;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      to_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (fall && !dat_f) begin
            state_q   <= RECV;
            bit_cnt_q <= '0;
          end
        end
        RECV: begin
          if (fall) begin
            to_cnt_q  <= '0;
            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            unique case (1'b1)
              (bit_cnt_q < PAR_IDX): begin
                shreg_q <= {dat_f, shreg_q[DATA_BITS-1:1]};
              end
              (bit_cnt_q == PAR_IDX): begin
                parity_q <= dat_f;
              end
              default: begin
                // flags land together with the DONE state
                rx_data_q  <= shreg_q;
                rx_valid_q <= 1'b1;
                perr_q     <= ~(^{shreg_q, parity_q});
                ferr_q     <= ~dat_f;
                state_q    <= DONE;
              end
            endcase
          end else if (to_cnt_q == TO_LAST) begin
            to_q      <= 1'b1;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        DONE: begin
          state_q   <= IDLE;
          bit_cnt_q <= '0;
          to_cnt_q  <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_timeout    = to_q;
  assign busy          = (state_q == RECV);
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Bench for ps2_frame_receiver: frame-level reference model with
// per-cycle compare, directed cases and randomized frames.
module tb_ps2_frame_receiver;
  localparam int SYNC = 2;
  localparam int FLEN = 8;
  localparam int TO = 300;
  localparam int LAT = SYNC + FLEN + 1;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_timeout;
  logic       busy;

  ps2_frame_receiver #(
    .SYNC_STAGES   (SYNC),
    .FILTER_LEN    (FLEN),
    .TIMEOUT_CYCLES(TO),
    .TO_W          (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2clk       (ps2clk),
    .ps2data      (ps2data),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_timeout   (rx_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Frame-level model: each accepted fall is (accept cycle, bit).
  bit   m_recv = 0;
  int   m_n = 0;
  int   m_last = 0;
  logic m_bits[10];
  ev_t  exp_ev[int];
  bit   exp_to[int];
  int   bs[$];
  int   be[$];

  function automatic void model_fall(input int a, input logic b);
    ev_t ev;
    logic [7:0] d;
    if (m_recv && a > m_last + TO) m_recv = 0;
    if (!m_recv) begin
      if (b == 1'b0) begin
        m_recv = 1;
        m_n = 0;
        m_last = a;
        exp_to[a + TO] = 1;
        bs.push_back(a);
        be.push_back(a + TO);
      end
    end else begin
      exp_to.delete(m_last + TO);
      m_last = a;
      m_bits[m_n] = b;
      m_n++;
      if (m_n == 10) begin
        for (int i = 0; i < 8; i++) d[i] = m_bits[i];
        ev.d = d;
        ev.pe = (($countones(d) + int'(m_bits[8])) % 2) == 0;
        ev.fe = (m_bits[9] == 1'b0);
        exp_ev[a] = ev;
        be[be.size() - 1] = a;
        m_recv = 0;
      end else begin
        exp_to[a + TO] = 1;
        be[be.size() - 1] = a + TO;
      end
    end
  endfunction

  function automatic void model_reset(input int r);
    if (m_recv) begin
      exp_to.delete(m_last + TO);
      be[be.size() - 1] = r;
      m_recv = 0;
    end
  endfunction

  logic [7:0] model_data = 8'h00;
  ev_t        cur_e;
  bit         exp_v;
  bit         busy_e;
  int         n_valid = 0;
  int         n_to = 0;
  logic [7:0] obs_data = 8'h00;
  logic       obs_pe = 1'b0;
  logic       obs_fe = 1'b0;
  int         obs_to_cyc = 0;
  logic [7:0] obs_q[$];

  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      model_data = 8'h00;
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_perr", rx_parity_err, 0);
      chk("rst_ferr", rx_frame_err, 0);
      chk("rst_timeout", rx_timeout, 0);
      chk("rst_busy", busy, 0);
    end else begin
      exp_v = exp_ev.exists(cyc);
      cur_e = '{d: 8'h00, pe: 1'b0, fe: 1'b0};
      if (exp_v) begin
        cur_e = exp_ev[cyc];
        model_data = cur_e.d;
      end
      busy_e = 0;
      foreach (bs[i])
        if (cyc >= bs[i] && cyc < be[i]) busy_e = 1;
      chk("rx_valid", rx_valid, exp_v);
      chk("rx_data", rx_data, model_data);
      chk("rx_parity_err", rx_parity_err, cur_e.pe);
      chk("rx_frame_err", rx_frame_err, cur_e.fe);
      chk("rx_timeout", rx_timeout, exp_to.exists(cyc));
      chk("busy", busy, busy_e);
    end
    if (rx_valid) begin
      n_valid++;
      obs_data = rx_data;
      obs_pe = rx_parity_err;
      obs_fe = rx_frame_err;
      obs_q.push_back(rx_data);
    end
    if (rx_timeout) begin
      n_to++;
      obs_to_cyc = cyc;
    end
  end

  int last_drive = 0;

  task automatic send_bit(input logic b, input int half);
    @(negedge clk);
    ps2data = b;
    repeat (half - 1) @(negedge clk);
    ps2clk = 1'b0;
    model_fall(cyc + LAT, b);
    last_drive = cyc;
    repeat (half) @(negedge clk);
    ps2clk = 1'b1;
  endtask

  task automatic glitch(input int half);
    repeat (half / 2) @(negedge clk);
    ps2clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stop, input int nbits,
                            input int glitch_at, input int half);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      send_bit(f[i], half);
      if (i == glitch_at) glitch(half);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       par;
    logic       stop;
    int         half;
    idle(5);
    rst_n = 1'b1;
    idle(20);

    // 0x1C has three ones, so odd parity needs parity bit 0
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 20);
    idle(30);
    chk("t1_count", n_valid, 1);
    chk("t1_data", obs_data, 8'h1C);
    chk("t1_perr", obs_pe, 0);
    chk("t1_ferr", obs_fe, 0);

    send_frame(8'h1C, 1'b1, 1'b1, 11, -1, 20);
    idle(30);
    chk("t2_count", n_valid, 2);
    chk("t2_data", obs_data, 8'h1C);
    chk("t2_perr", obs_pe, 1);
    chk("t2_ferr", obs_fe, 0);

    send_frame(8'hF0, 1'b1, 1'b0, 11, -1, 20);
    idle(30);
    chk("t3_count", n_valid, 3);
    chk("t3_data", obs_data, 8'hF0);
    chk("t3_perr", obs_pe, 0);
    chk("t3_ferr", obs_fe, 1);

    glitch(20);
    idle(30);
    chk("t4_idle_busy", busy, 0);
    send_frame(8'h5A, 1'b1, 1'b1, 11, 4, 20);
    idle(30);
    chk("t4_count", n_valid, 4);
    chk("t4_data", obs_data, 8'h5A);
    chk("t4_perr", obs_pe, 0);

    send_frame(8'hC3, 1'b1, 1'b1, 5, -1, 20);
    idle(TO + 40);
    chk("t5_to_count", n_to, 1);
    chk("t5_to_cycle", obs_to_cyc, last_drive + LAT + TO);
    chk("t5_valid_count", n_valid, 4);
    chk("t5_data_hold", rx_data, 8'h5A);
    chk("t5_busy", busy, 0);
    send_frame(8'h5A, 1'b1, 1'b1, 11, -1, 20);
    idle(30);
    chk("t5_count", n_valid, 5);
    chk("t5_data", obs_data, 8'h5A);

    send_frame(8'h33, 1'b1, 1'b1, 5, -1, 20);
    idle(5);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset(cyc + 1);
    idle(5);
    rst_n = 1'b1;
    ps2data = 1'b1;
    idle(30);
    chk("t6_count", n_valid, 5);
    chk("t6_data", rx_data, 8'h00);
    chk("t6_to_count", n_to, 1);
    send_frame(8'hE0, 1'b0, 1'b1, 11, -1, 20);
    send_frame(8'h75, 1'b0, 1'b1, 11, -1, 20);
    idle(30);
    chk("t6_b2b_count", n_valid, 7);
    chk("t6_first", obs_q[obs_q.size() - 2], 8'hE0);
    chk("t6_second", obs_q[obs_q.size() - 1], 8'h75);
    chk("t6_perr", obs_pe, 0);

    for (int k = 0; k < 25; k++) begin
      d = 8'($urandom);
      par = ~^d;
      if ($urandom_range(0, 4) == 0) par = ~par;
      stop = ($urandom_range(0, 5) != 0);
      half = $urandom_range(16, 30);
      if ($urandom_range(0, 3) == 0) send_bit(1'b1, half);
      send_frame(d, par, stop, 11, -1, half);
      idle($urandom_range(0, 50));
    end
    idle(40);
    chk("rand_count", n_valid, 32);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
